// File: rtl/axi_mem_master_bridge_if.sv
// AXI4 bus bundle for the memory-to-AXI master bridge.
// Master modport drives requests; slave modport drives responses.
interface axi_mem_master_bridge_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
    output aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
    output ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
    input  aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
    input  ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_master_bridge.sv
// Single-port memory request to single-beat AXI4 master, one txn in flight.
// Define AXI_MASTER_ERR_EN to report non-OKAY responses on err_o.
module axi_mem_master_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 1,
  parameter int AXI_ID         = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic                        we_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  axi_mem_master_bridge_if.master     master
);
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = 3'($clog2(SW));

  typedef enum logic [2:0] {
    IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA
  } state_t;

  state_t                    r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [SW-1:0]             r_be;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic                      r_aw_valid;
  logic                      r_w_valid;
  logic                      r_ar_valid;
  logic                      r_b_ready;
  logic                      r_r_ready;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic w_aw_fin, w_w_fin;
  logic w_b_err, w_r_err;

  assign gnt_o    = (r_state == IDLE) && req_i;
  assign w_aw_hs  = r_aw_valid && master.aw_ready;
  assign w_w_hs   = r_w_valid && master.w_ready;
  assign w_ar_hs  = r_ar_valid && master.ar_ready;
  assign w_b_hs   = r_b_ready && master.b_valid;
  assign w_r_hs   = r_r_ready && master.r_valid;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done || w_w_hs;

`ifdef AXI_MASTER_ERR_EN
  logic r_err_seen;
  logic w_unused;

  assign w_b_err = master.b_resp != 2'b00;
  assign w_r_err = master.r_resp != 2'b00;

  // Sticky record of any error response since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_seen <= 1'b0;
    end else if ((w_b_hs && w_b_err) || (w_r_hs && w_r_err)) begin
      r_err_seen <= 1'b1;
    end
  end

  assign w_unused = ^{master.b_id, master.b_user, master.r_id,
                      master.r_last, master.r_user, r_err_seen};
`else
  logic w_unused;

  assign w_b_err  = 1'b0;
  assign w_r_err  = 1'b0;
  assign w_unused = ^{master.b_id, master.b_user, master.b_resp,
                      master.r_id, master.r_last, master.r_user,
                      master.r_resp};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_ar_valid <= 1'b0;
      r_b_ready  <= 1'b0;
      r_r_ready  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_i) begin
            r_addr  <= addr_i;
            r_be    <= be_i;
            r_wdata <= wdata_i;
            if (we_i) begin
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
              r_aw_done  <= 1'b0;
              r_w_done   <= 1'b0;
              r_state    <= WRITE;
            end else begin
              r_ar_valid <= 1'b1;
              r_state    <= RD_ADDR;
            end
          end
        end
        // AW and W complete independently, possibly together.
        WRITE: begin
          if (w_aw_hs) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_valid <= 1'b0;
            r_w_done  <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_b_ready <= 1'b1;
            r_state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (w_b_hs) begin
            r_b_ready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_err     <= w_b_err;
            r_state   <= IDLE;
          end
        end
        RD_ADDR: begin
          if (w_ar_hs) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (w_r_hs) begin
            r_r_ready <= 1'b0;
            r_rdata   <= master.r_data;
            r_rvalid  <= 1'b1;
            r_err     <= w_r_err;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.aw_addr   = r_addr;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = SIZE;
  assign master.aw_burst  = 2'b01;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_user   = '0;
  assign master.aw_valid  = r_aw_valid;

  assign master.w_data    = r_wdata;
  assign master.w_strb    = r_be;
  assign master.w_last    = 1'b1;
  assign master.w_user    = '0;
  assign master.w_valid   = r_w_valid;

  assign master.b_ready   = r_b_ready;

  assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign master.ar_addr   = r_addr;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = SIZE;
  assign master.ar_burst  = 2'b01;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = '0;
  assign master.ar_valid  = r_ar_valid;

  assign master.r_ready   = r_r_ready;
endmodule

// File: tb/tb_axi_mem_master_bridge.sv
// Scoreboard bench for axi_mem_master_bridge with a delay-programmable AXI slave.
// Expected completions come from a byte-enable memory model evaluated at grant.
module tb_axi_mem_master_bridge;
  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  axi_mem_master_bridge_if #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(1)
  ) bus ();

  axi_mem_master_bridge #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(1), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .master(bus.master)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          gcyc;
  } exp_t;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int n_gnt = 0;
  int n_rv = 0;
  logic [31:0] last_rdata = 0;
  exp_t exp_q[$];
  txn_t cfg_q[$];
  // index {0,addr}: reference model; {1,addr}: slave storage
  logic [31:0] mem [logic [32:0]];

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mrd(input bit s, input logic [31:0] a);
    if (mem.exists({s, a})) return mem[{s, a}];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void mwr(input bit s, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = mrd(s, a);
    for (int b = 0; b < 4; b++)
      if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    mem[{s, a}] = v;
  endfunction

  function automatic txn_t mk(input bit we, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] d,
                              input int awd, input int wd, input int bd,
                              input int ard, input int rd,
                              input logic [1:0] resp);
    txn_t t;
    t.we = we; t.addr = a; t.be = be; t.wdata = d;
    t.aw_d = awd; t.w_d = wd; t.b_d = bd;
    t.ar_d = ard; t.r_d = rd; t.resp = resp;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    int r;
    t.we = 1'($urandom_range(0, 1));
    t.addr = 32'hC000 | (32'($urandom_range(0, 7)) << 2);
    t.be = 4'($urandom_range(0, 15));
    t.wdata = $urandom;
    t.aw_d = $urandom_range(0, 3);
    t.w_d = $urandom_range(0, 3);
    t.b_d = $urandom_range(0, 3);
    t.ar_d = $urandom_range(0, 3);
    t.r_d = $urandom_range(0, 3);
    r = $urandom_range(0, 5);
    t.resp = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : 2'b00;
    return t;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Grant-time bookkeeping: model update plus expected completion.
  task automatic issue(input txn_t t);
    exp_t e;
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = t.we; addr_i = t.addr;
    be_i = t.be; wdata_i = t.wdata;
    for (int i = 0; i < 300 && !got; i++) begin
      #1;
      if (gnt_o) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("gnt_timeout", 0, 1);
      return;
    end
    chk("gnt_while_busy", exp_q.size(), 0);
    n_gnt++;
    e.gcyc = cyc;
    if (t.we) begin
      mwr(1'b0, t.addr, t.be, t.wdata);
      e.rdata = last_rdata;
      e.lat = 3 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + t.b_d;
    end else begin
      e.rdata = mrd(1'b0, t.addr);
      last_rdata = e.rdata;
      e.lat = 3 + t.ar_d + t.r_d;
    end
`ifdef AXI_MASTER_ERR_EN
    e.err = (t.resp != 2'b00);
`else
    e.err = 1'b0;
`endif
    exp_q.push_back(e);
    cfg_q.push_back(t);
  endtask

  task automatic idle();
    @(negedge clk);
    req_i = 1'b0;
    we_i = 1'b0;
  endtask

  // Monitor: pops one expectation per completion pulse.
  bit prev_rv = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (rvalid_o) begin
        n_rv++;
        chk("rvalid_pulse", prev_rv, 0);
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", rdata_o, e.rdata);
          chk("err", err_o, e.err);
          chk("latency", cyc - e.gcyc, e.lat);
        end
      end
      prev_rv = rvalid_o;
    end
  end

  // AXI slave: per-transaction delays and response from cfg_q.
  txn_t sc;
  bit have, aw_got, w_got, ar_got, b_fire, r_fire;
  bit paw, pw, par;
  int awc, wc, bc, arc, rc, aw_h, w_h, ar_h;

  initial begin
    bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
    bus.b_valid = 0; bus.b_resp = 0; bus.b_id = 0; bus.b_user = 0;
    bus.r_valid = 0; bus.r_resp = 0; bus.r_id = 0; bus.r_user = 0;
    bus.r_data = 0; bus.r_last = 0;
    have = 0; aw_got = 0; w_got = 0; ar_got = 0;
    b_fire = 0; r_fire = 0; paw = 0; pw = 0; par = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
        bus.b_valid = 0; bus.r_valid = 0;
        have = 0; aw_got = 0; w_got = 0; ar_got = 0;
        b_fire = 0; r_fire = 0; paw = 0; pw = 0; par = 0;
      end else begin
        if (paw) chk("aw_valid_withdrawn", bus.aw_valid, 1);
        if (pw) chk("w_valid_withdrawn", bus.w_valid, 1);
        if (par) chk("ar_valid_withdrawn", bus.ar_valid, 1);
        if (b_fire) begin
          bus.b_valid = 0; b_fire = 0; have = 0;
          aw_got = 0; w_got = 0;
        end
        if (r_fire) begin
          bus.r_valid = 0; r_fire = 0; have = 0; ar_got = 0;
        end
        if (bus.aw_valid || bus.ar_valid)
          chk("aw_ar_overlap", bus.aw_valid && bus.ar_valid, 0);
        if (bus.b_ready) chk("b_ready_early", aw_got && w_got, 1);
        if (bus.r_ready) chk("r_ready_early", ar_got, 1);
        if (aw_got) chk("aw_valid_drop", bus.aw_valid, 0);
        if (w_got) chk("w_valid_drop", bus.w_valid, 0);
        if (ar_got) chk("ar_valid_drop", bus.ar_valid, 0);
        if (!have && (bus.aw_valid || bus.w_valid || bus.ar_valid)) begin
          if (cfg_q.size() == 0) begin
            chk("axi_unexpected", 1, 0);
          end else begin
            sc = cfg_q.pop_front();
            have = 1;
            awc = sc.aw_d; wc = sc.w_d; bc = sc.b_d;
            arc = sc.ar_d; rc = sc.r_d;
            aw_h = 0; w_h = 0; ar_h = 0;
          end
        end
        if (have && aw_got && w_got && !bus.b_valid && !b_fire) begin
          if (bc == 0) begin
            bus.b_valid = 1; bus.b_resp = sc.resp;
          end else bc--;
        end
        if (have && ar_got && !bus.r_valid && !r_fire) begin
          if (rc == 0) begin
            bus.r_valid = 1; bus.r_resp = sc.resp; bus.r_last = 1;
            bus.r_data = mrd(1'b1, sc.addr);
          end else rc--;
        end
        if (bus.b_valid && bus.b_ready) b_fire = 1;
        if (bus.r_valid && bus.r_ready) r_fire = 1;

        if (have && bus.aw_valid && !aw_got) begin
          aw_h++;
          if (awc == 0) begin
            bus.aw_ready = 1; aw_got = 1;
            chk("aw_hold_cycles", aw_h, sc.aw_d + 1);
            chk("aw_addr", bus.aw_addr, sc.addr);
            chk("aw_fields",
                {bus.aw_id, bus.aw_len, bus.aw_size, bus.aw_burst},
                {6'd0, 8'd0, 3'd2, 2'b01});
            chk("aw_zero_fields",
                {bus.aw_lock, bus.aw_cache, bus.aw_prot,
                 bus.aw_qos, bus.aw_region, bus.aw_user}, 0);
          end else begin
            bus.aw_ready = 0; awc--;
          end
        end else bus.aw_ready = 1'($urandom_range(0, 1));

        if (have && bus.w_valid && !w_got) begin
          w_h++;
          if (wc == 0) begin
            bus.w_ready = 1; w_got = 1;
            chk("w_hold_cycles", w_h, sc.w_d + 1);
            chk("w_data", bus.w_data, sc.wdata);
            chk("w_strb", bus.w_strb, sc.be);
            chk("w_last", bus.w_last, 1);
            mwr(1'b1, sc.addr, bus.w_strb, bus.w_data);
          end else begin
            bus.w_ready = 0; wc--;
          end
        end else bus.w_ready = 1'($urandom_range(0, 1));

        if (have && bus.ar_valid && !ar_got) begin
          ar_h++;
          if (arc == 0) begin
            bus.ar_ready = 1; ar_got = 1;
            chk("ar_hold_cycles", ar_h, sc.ar_d + 1);
            chk("ar_addr", bus.ar_addr, sc.addr);
            chk("ar_fields",
                {bus.ar_id, bus.ar_len, bus.ar_size, bus.ar_burst},
                {6'd0, 8'd0, 3'd2, 2'b01});
          end else begin
            bus.ar_ready = 0; arc--;
          end
        end else bus.ar_ready = 1'($urandom_range(0, 1));

        paw = bus.aw_valid && !bus.aw_ready;
        pw  = bus.w_valid && !bus.w_ready;
        par = bus.ar_valid && !bus.ar_ready;
      end
    end
  end

  task automatic reset_checks();
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_aw_valid", bus.aw_valid, 0);
    chk("rst_w_valid", bus.w_valid, 0);
    chk("rst_ar_valid", bus.ar_valid, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_r_ready", bus.r_ready, 0);
  endtask

  initial begin
    bit seen;
    int waited;
    rst_n = 1'b1; req_i = 0; we_i = 0;
    addr_i = 0; be_i = 0; wdata_i = 0;
    #3 rst_n = 1'b0;
    #1 reset_checks();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // zero-wait write, single byte lane
    issue(mk(1, 32'hC000, 4'b0001, 32'h0000_00A5, 0, 0, 0, 0, 0, 2'b00));
    idle();
    // read with AR accepted after 4 wait cycles
    mwr(1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
    mwr(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    issue(mk(0, 32'h10, 4'h0, 32'h0, 0, 0, 0, 4, 0, 2'b00));
    idle();
    // AW stalls 3 cycles while W is accepted at once
    issue(mk(1, 32'hC004, 4'b1010, 32'h1234_5678, 3, 0, 1, 0, 0, 2'b00));
    idle();
    // W stalls while AW is accepted at once
    issue(mk(1, 32'hC008, 4'b1111, 32'hCAFE_F00D, 0, 2, 0, 0, 0, 2'b00));
    idle();
    // back-to-back: two writes then a read with req held high
    issue(mk(1, 32'hC00C, 4'b1111, 32'h1111_2222, 0, 0, 0, 0, 0, 2'b00));
    issue(mk(1, 32'hC00C, 4'b0110, 32'hAAAA_BBBB, 1, 0, 0, 0, 0, 2'b00));
    issue(mk(0, 32'hC00C, 4'b0000, 32'h0, 0, 0, 0, 0, 2, 2'b00));
    idle();
    // error responses
    issue(mk(1, 32'hC010, 4'b1111, 32'h5555_AAAA, 0, 0, 0, 0, 0, 2'b10));
    issue(mk(0, 32'hC010, 4'b0000, 32'h0, 0, 0, 0, 1, 0, 2'b10));
    idle();
    issue(mk(0, 32'hC000, 4'b0000, 32'h0, 0, 0, 0, 0, 0, 2'b00));
    idle();

    // reset while the bridge is waiting in the read-data phase
    issue(mk(0, 32'hC004, 4'b0000, 32'h0, 0, 0, 0, 0, 12, 2'b00));
    idle();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.r_ready) seen = 1'b1;
    end
    chk("reach_rd_data", seen, 1);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    exp_q.delete();
    cfg_q.delete();
    last_rdata = 0;
    n_gnt = 0;
    n_rv = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(mk(0, 32'hC004, 4'b0000, 32'h0, 0, 0, 0, 0, 0, 2'b00));
    idle();

    for (int i = 0; i < 60; i++) begin
      issue(rnd_txn());
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_cfg", cfg_q.size(), 0);
    chk("gnt_vs_rvalid", n_gnt, n_rv);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #300000;
    errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
